day12_seq_serializer: RTL and testbench
=======================================

// Module: day12_seq_serializer
// PURPOSE
//  Parallel-to-serial pattern generator; transmit-side counterpart of the day12 serial sequence detector.
//  Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk on ser_o.
//  ser_o drives a detector's x_i directly; done_o marks the last bit of each frame.
//  Sits between a pattern source (bench or CPU register) and the serial line.
// PARAMETERS
//  WIDTH      12    frame length in data bits, >= 2
//  LSB_FIRST  1     1: bit 0 sent first; 0: bit WIDTH-1 sent first
//  IDLE_LVL   1'b1  level driven on ser_o when no bit is being sent
//  GAP        1     idle cycles inserted after each frame, 0..15
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      synchronous, active-high
//  load_valid_i  in   1      load_data_i is valid
//  load_data_i   in   WIDTH  word to transmit
//  load_ready_o  out  1      serializer can accept a word this cycle
//  ser_o         out  1      serial data bit, registered
//  ser_valid_o   out  1      ser_o carries a frame bit this cycle, registered
//  done_o        out  1      one-cycle pulse coincident with the last bit of a frame, registered
// BEHAVIOUR
//  - Reset (sync) values: state=IDLE, ser_o=IDLE_LVL, ser_valid_o=0, done_o=0, bit counter=0, shift reg=0.
//  - load_ready_o = (state==IDLE) & ~reset; combinational, 0 while reset is high.
//  - FSM: IDLE -> SHIFT on valid&ready; SHIFT -> GAP after last bit (or IDLE if GAP==0); GAP -> IDLE after GAP cycles.
//  - Accept: at the posedge where load_valid_i & load_ready_o, word captured into shift reg.
//  - Latency: first bit on ser_o in the cycle after accept. WIDTH consecutive cycles with ser_valid_o=1.
//  - Order: LSB_FIRST=1 sends data[0]..data[WIDTH-1]; LSB_FIRST=0 sends data[WIDTH-1]..data[0].
//  - done_o=1 only in the cycle the final frame bit is on ser_o; 0 otherwise.
//  - Bit counter is $clog2(WIDTH+1) bits wide, counts 0..WIDTH-1 and never wraps inside a frame.
//  - Gap: GAP cycles with ser_o=IDLE_LVL, ser_valid_o=0; load_ready_o stays 0 during them.
//  - Back-to-back: with GAP=0 and valid held high, frames are separated by exactly 1 idle cycle
//    (the IDLE accept cycle). Minimum frame period = WIDTH+GAP+1 cycles.
//  - load_valid_i while not ready: ignored. Source must hold data/valid until accepted.
//  - load_data_i changes during SHIFT/GAP: no effect on the frame in flight.
//  - Reset mid-frame: at that posedge all outputs return to reset values.
//    The frame is aborted, no done_o, and the word is not resumed.
//  - Simultaneous reset and load_valid_i: reset wins, word not accepted.
// CONFIGURATION
//  SER_PARITY_EN defined:
//    - one extra bit follows the last data bit: even parity (XOR of all WIDTH data bits).
//    - ser_valid_o=1 for WIDTH+1 cycles; done_o moves to the parity-bit cycle; GAP follows it.
//    - minimum frame period = WIDTH+GAP+2 cycles.
//  SER_PARITY_EN undefined: no parity state or logic; frames are exactly WIDTH bits.
// TESTING
//  1 Reset: hold reset 2 cycles -> ser_o=1, ser_valid_o=0, done_o=0, load_ready_o=0; release -> load_ready_o=1.
//  2 Basic frame, LSB_FIRST=1: load 12'hEDB
//    -> cycles 1..12 after accept ser_o = 1,1,0,1,1,0,1,1,0,1,1,1 with ser_valid_o=1.
//    -> done_o high only on cycle 12; load_ready_o=0 for cycles 1..12+GAP.
//  3 Handshake: valid held high with two words 12'hEDB then 12'h0F0, GAP=0
//    -> second frame's first bit 14 cycles after the first accept (1 idle cycle between frames).
//    -> data changes while busy are not sent.
//  4 Reset mid-frame: reset asserted after 5 bits of 12'hFFF
//    -> next cycle ser_o=1, ser_valid_o=0, done_o never pulses; a new load afterwards sends a full 12-bit frame.
//  5 Loopback: ser_o -> day12 x_i, load 12'b1110_1101_1011 -> detector det_o asserts per its spec; 12'h000 -> det_o stays 0.
//  6 SER_PARITY_EN, load 12'hEDB (9 ones)
//    -> 13th bit=1 with ser_valid_o=1 and done_o=1; load 12'h003 -> 13th bit=0.

Source files
------------

// File: rtl/day12_seq_serializer.sv
// day12_seq_serializer
//   Parallel-to-serial pattern generator feeding the day12 serial sequence
//   detector. A WIDTH-bit word is accepted over a valid/ready handshake and
//   shifted out one bit per clock on ser_o, qualified by ser_valid_o, with
//   done_o marking the final bit of each frame. GAP idle cycles follow every
//   frame before the next word can be accepted.
//
//   Optional feature macro: SER_PARITY_EN
//     defined   : an even-parity bit (XOR of all data bits) is appended after
//                 the last data bit; done_o marks the parity bit instead.
//     undefined : frames are exactly WIDTH data bits, no parity logic.
module day12_seq_serializer #(
  parameter int   WIDTH     = 12,
  parameter bit   LSB_FIRST = 1'b1,
  parameter logic IDLE_LVL  = 1'b1,
  parameter int   GAP       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_ready_o,
  output logic             ser_o,
  output logic             ser_valid_o,
  output logic             done_o
);

  localparam int             CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_IDX   = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  PENULT_IDX = CW'(WIDTH - 2);
  localparam logic [3:0]     GAP_LAST   = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
`ifdef SER_PARITY_EN
  localparam logic [1:0] S_PAR   = 2'd3;
`endif
  // State entered once the final bit of a frame has been sent.
  localparam logic [1:0] S_AFTER = (GAP == 0) ? S_IDLE : S_GAP;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;      // current bit always sits at the outgoing end
  logic [CW-1:0]    bit_cnt;    // index of the bit currently on ser_o
  logic [3:0]       gap_cnt;
`ifdef SER_PARITY_EN
  logic             par_bit;
`endif

  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_adv;

  // Handshake and bit-selection helpers; reset forces ready low immediately.
  // NOTE: continuous assigns are fully specified, so no storage is implied;
  // every combinational output here has a value on every path.
  assign load_ready_o = (state == S_IDLE) & ~reset;
  assign accept       = load_valid_i & load_ready_o;
  assign first_bit    = LSB_FIRST ? load_data_i[0] : load_data_i[WIDTH-1];
  assign next_bit     = LSB_FIRST ? shreg[1]       : shreg[WIDTH-2];
  assign shreg_adv    = LSB_FIRST ? (shreg >> 1)   : (shreg << 1);

  // Frame sequencer: loads the word, walks the bits, then holds off for GAP.
  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shift register is reset too, so an aborted frame leaves
      // no stale data behind; it is a plain register, not a memory array.
      state       <= S_IDLE;
      ser_o       <= IDLE_LVL;
      ser_valid_o <= 1'b0;
      done_o      <= 1'b0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      shreg       <= '0;
`ifdef SER_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg       <= load_data_i;
            ser_o       <= first_bit;
            ser_valid_o <= 1'b1;
            done_o      <= 1'b0;
            bit_cnt     <= '0;
`ifdef SER_PARITY_EN
            par_bit     <= ^load_data_i;
`endif
            state       <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (bit_cnt == LAST_IDX) begin
`ifdef SER_PARITY_EN
            ser_o       <= par_bit;
            ser_valid_o <= 1'b1;
            done_o      <= 1'b1;
            state       <= S_PAR;
`else
            ser_o       <= IDLE_LVL;
            ser_valid_o <= 1'b0;
            done_o      <= 1'b0;
            gap_cnt     <= '0;
            state       <= S_AFTER;
`endif
          end else begin
            shreg       <= shreg_adv;
            ser_o       <= next_bit;
            ser_valid_o <= 1'b1;
`ifdef SER_PARITY_EN
            done_o      <= 1'b0;
`else
            done_o      <= (bit_cnt == PENULT_IDX);
`endif
            bit_cnt     <= bit_cnt + 1'b1;
          end
        end

`ifdef SER_PARITY_EN
        S_PAR: begin
          ser_o       <= IDLE_LVL;
          ser_valid_o <= 1'b0;
          done_o      <= 1'b0;
          gap_cnt     <= '0;
          state       <= S_AFTER;
        end
`endif

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          ser_o       <= IDLE_LVL;
          ser_valid_o <= 1'b0;
          done_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_day12_seq_serializer.sv
// tb_day12_seq_serializer
//   Two serializer instances: dut0 (LSB first, GAP=1) and dut1 (MSB first,
//   GAP=0). Every accepted word pushes its expected bit stream, tagged with
//   the cycle each bit is due, into a per-instance queue; a negedge monitor
//   pops and compares ser_o/done_o and checks ready/idle behaviour between
//   frames. Honours SER_PARITY_EN the same way as the design.
module tb_day12_seq_serializer;

  localparam int W  = 12;
  localparam int G0 = 1;
  localparam int G1 = 0;
`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct {
    logic b;
    logic last;
    int   due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst0, rst1;
  logic         valid0, valid1;
  logic [W-1:0] data0, data1;
  logic         rdy0, rdy1, ser0, ser1, sv0, sv1, dn0, dn1;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_err    = 0;
  int   end_cyc[2];
  bit   mon_en   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  day12_seq_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1), .GAP(G0)) dut0 (
    .clk(clk), .reset(rst0), .load_valid_i(valid0), .load_data_i(data0),
    .load_ready_o(rdy0), .ser_o(ser0), .ser_valid_o(sv0), .done_o(dn0));

  day12_seq_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LVL(1'b1), .GAP(G1)) dut1 (
    .clk(clk), .reset(rst1), .load_valid_i(valid1), .load_data_i(data1),
    .load_ready_o(rdy1), .ser_o(ser1), .ser_valid_o(sv1), .done_o(dn1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected bit stream for one word; base is the cycle of the first bit.
  task automatic push_frame(input int d, input logic [W-1:0] w, input int base);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b    = (d == 0) ? w[i] : w[W-1-i];
      e.last = (PB == 0) && (i == W - 1);
      e.due  = base + i;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (PB != 0) begin
      e.b    = ^w;
      e.last = 1'b1;
      e.due  = base + W;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic mon(input int d, input logic s, input logic v, input logic dn,
                     input logic rdy, input logic rs);
    int   g;
    int   qs;
    exp_t e;
    g  = (d == 0) ? G0 : G1;
    qs = (d == 0) ? q0.size() : q1.size();
    if (v === 1'b1) begin
      if (qs == 0) begin
        check($sformatf("d%0d_spurious_bit", d), 32'(v), 32'd0);
      end else begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        check($sformatf("d%0d_bit_time", d), 32'(cyc), 32'(e.due));
        check($sformatf("d%0d_ser_bit", d), 32'(s), 32'(e.b));
        check($sformatf("d%0d_done", d), 32'(dn), 32'(e.last));
        check($sformatf("d%0d_ready_busy", d), 32'(rdy), 32'd0);
        if (e.last) end_cyc[d] = cyc;
      end
    end else begin
      check($sformatf("d%0d_idle_lvl", d), 32'(s), 32'd1);
      check($sformatf("d%0d_done_idle", d), 32'(dn), 32'd0);
      if (qs > 0) begin
        e = (d == 0) ? q0[0] : q1[0];
        if (e.due <= cyc) begin
          check($sformatf("d%0d_missing_bit", d), 32'(v), 32'd1);
          if (d == 0) q0.delete(); else q1.delete();
        end
      end
      if (cyc > end_cyc[d] && cyc <= end_cyc[d] + g)
        check($sformatf("d%0d_ready_gap", d), 32'(rdy), 32'd0);
      else if (cyc == end_cyc[d] + g + 1 && rs == 1'b0)
        check($sformatf("d%0d_ready_after", d), 32'(rdy), 32'd1);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, ser0, sv0, dn0, rdy0, rst0);
      mon(1, ser1, sv1, dn1, rdy1, rst1);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Present a word and hold it until accepted; valid stays high on return.
  task automatic send(input int d, input logic [W-1:0] w, output int base);
    bit done;
    done = 1'b0;
    base = -1;
    if (d == 0) begin valid0 = 1'b1; data0 = w; end
    else        begin valid1 = 1'b1; data1 = w; end
    for (int n = 0; n < 200 && !done; n++) begin
      #1;
      if (((d == 0) ? rdy0 : rdy1) === 1'b1) begin
        base = cyc + 1;
        push_frame(d, w, base);
        @(posedge clk);
        #1;
        if (d == 0) data0 = ~w; else data1 = ~w;
        done = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    if (!done) check($sformatf("d%0d_accept_timeout", d), 32'd0, 32'd1);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
      step(1);
      n++;
    end
    check($sformatf("d%0d_drain", d), 32'((d == 0) ? q0.size() : q1.size()), 32'd0);
    step(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b1, b2, b3;
    end_cyc[0] = -100;
    end_cyc[1] = -100;
    rst0 = 1'b1; rst1 = 1'b1;
    valid0 = 1'b0; valid1 = 1'b0;
    data0 = '0; data1 = '0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_ser", 32'(ser0), 32'd1);
    check("rst_valid", 32'(sv0), 32'd0);
    check("rst_done", 32'(dn0), 32'd0);
    check("rst_ready", 32'(rdy0), 32'd0);
    check("rst_ready_d1", 32'(rdy1), 32'd0);
    @(negedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    check("rel_ready", 32'(rdy0), 32'd1);
    check("rel_ready_d1", 32'(rdy1), 32'd1);

    // Basic frames, LSB first with a one-cycle gap.
    send(0, 12'hEDB, b1); valid0 = 1'b0; drain(0);
    send(0, 12'h000, b1); valid0 = 1'b0; drain(0);
    send(0, 12'hFFF, b1); valid0 = 1'b0; drain(0);
    send(0, 12'h003, b1); valid0 = 1'b0; drain(0);
    for (int i = 0; i < 3; i++) begin
      send(0, W'($urandom), b1); valid0 = 1'b0; drain(0);
    end

    // Back-to-back on the MSB-first, zero-gap instance; valid never drops.
    send(1, 12'hEDB, b1);
    data1 = 12'h555;
    step(3);
    send(1, 12'h0F0, b2);
    check("b2b_period_1", 32'(b2 - b1), 32'(W + G1 + 1 + PB));
    send(1, W'($urandom), b3);
    check("b2b_period_2", 32'(b3 - b2), 32'(W + G1 + 1 + PB));
    valid1 = 1'b0;
    drain(1);

    // Back-to-back on the gapped instance.
    send(0, 12'hA5C, b1);
    send(0, 12'h3C7, b2);
    check("b2b_period_gap", 32'(b2 - b1), 32'(W + G0 + 1 + PB));
    valid0 = 1'b0;
    drain(0);

    // Reset and valid together: reset wins, nothing is accepted.
    rst0 = 1'b1; valid0 = 1'b1; data0 = 12'hABC;
    #1;
    check("rst_vs_valid_ready", 32'(rdy0), 32'd0);
    @(posedge clk);
    #1;
    rst0 = 1'b0; valid0 = 1'b0;
    step(4);

    // Reset after five bits of 12'hFFF: frame aborted, no done pulse.
    send(0, 12'hFFF, b1);
    valid0 = 1'b0;
    step(4);
    rst0 = 1'b1;
    #1;
    check("midframe_rst_ready", 32'(rdy0), 32'd0);
    @(posedge clk);
    #1;
    q0.delete();
    rst0 = 1'b0;
    step(3);
    send(0, 12'hFFF, b1); valid0 = 1'b0; drain(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
